// File: rtl/acc_unit_4bit_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_unit_4bit_if
// Purpose  : Bundle for the 4-bit accumulator. It carries the command
//            handshake, the side-channel to the external adder_sub_4bit,
//            and the result/flags handshake.
// Revision : 1.0  initial release
// ============================================================================
interface acc_unit_4bit_if;
  // command side
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [3:0] operand;
  // adder side-channel
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_sel;
  logic [3:0] add_s;
  logic       add_cout;
  // result side
  logic       out_valid;
  logic       out_ready;
  logic [3:0] acc;
  logic       carry;
  logic       ovf;
  logic       zero;
  logic       neg;

  // Environment view: issues commands, hosts the adder, consumes results.
  modport master (
    output in_valid, op, operand, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_sel, out_valid, acc, carry, ovf, zero, neg
  );

  // Accumulator view.
  modport slave (
    input  in_valid, op, operand, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_sel, out_valid, acc, carry, ovf, zero, neg
  );
endinterface
`default_nettype wire

// File: rtl/acc_unit_4bit.sv
`default_nettype none
// ============================================================================
// Module   : acc_unit_4bit
// Purpose  : 4-bit accumulator that sits downstream of adder_sub_4bit. It
//            takes LOAD/ADD/SUB/CLEAR commands, runs ADD/SUB through the
//            external adder, and registers the acc value with its
//            carry/ovf/zero/neg flags.
// Options  : ACC_SATURATE_EN - when defined, ADD/SUB saturate to 0111/1000
//            on signed overflow instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module acc_unit_4bit (
  input  wire logic         clk,
  input  wire logic         rst,
  acc_unit_4bit_if.slave    bus
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] operand_q, operand_d;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic       zero_q, zero_d;
  logic       neg_q, neg_d;

  logic       w_is_sub;
  logic [3:0] w_beff;
  logic       w_ovf;
  logic [3:0] w_arith;

  // The adder subtracts as A + ~B + 1, so the sign test uses the inverted operand.
  assign w_is_sub = (op_q == OP_SUB);
  assign w_beff   = w_is_sub ? ~operand_q : operand_q;
  assign w_ovf    = (acc_q[3] == w_beff[3]) && (bus.add_s[3] != acc_q[3]);

`ifdef ACC_SATURATE_EN
  // Clamp toward the sign of the original accumulator when overflow occurs.
  assign w_arith  = w_ovf ? (acc_q[3] ? 4'b1000 : 4'b0111) : bus.add_s;
`else
  assign w_arith  = bus.add_s;
`endif

  // Drive the adder from registered state; it is neutral outside EXEC.
  assign bus.add_a   = acc_q;
  assign bus.add_b   = (state_q == S_EXEC) ? operand_q : 4'b0000;
  assign bus.add_sel = (state_q == S_EXEC) && w_is_sub;

  // in_ready is held low while reset is asserted, even though the state is IDLE.
  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_RESP);
  assign bus.acc       = acc_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

  // Next-state and datapath: capture the command, execute it once, then hold the result.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d      = bus.op;
          operand_d = bus.operand;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD: begin
            acc_d   = operand_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc_d   = w_arith;
            carry_d = bus.add_cout;
            ovf_d   = w_ovf;
          end
          default: begin
            acc_d   = 4'b0000;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
        endcase
        zero_d  = (acc_d == 4'b0000);
        neg_d   = acc_d[3];
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any command that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LOAD;
      operand_q <= 4'b0000;
      acc_q     <= 4'b0000;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_unit_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_unit_4bit
// Purpose  : Scoreboard bench for acc_unit_4bit. It models adder_sub_4bit
//            and issues directed commands, then checks every result beat
//            against hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_acc_unit_4bit;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef struct packed {
    logic [3:0] acc;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       neg;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  acc_unit_4bit_if bus ();

  acc_unit_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural adder_sub_4bit: S = A + (sel ? ~B : B) + sel.
  logic [4:0] w_sum;
  assign w_sum        = {1'b0, bus.add_a} + {1'b0, (bus.add_sel ? ~bus.add_b : bus.add_b)} + {4'b0000, bus.add_sel};
  assign bus.add_s    = w_sum[3:0];
  assign bus.add_cout = w_sum[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] a, input logic c, input logic v);
    exp_t e;
    e.acc   = a;
    e.carry = c;
    e.ovf   = v;
    e.zero  = (a == 4'b0000);
    e.neg   = a[3];
    return e;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result beat must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got acc=%b with no pending command at %0t", bus.acc, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc",   bus.acc,            e.acc);
        chk("carry", {3'b000, bus.carry}, {3'b000, e.carry});
        chk("ovf",   {3'b000, bus.ovf},   {3'b000, e.ovf});
        chk("zero",  {3'b000, bus.zero},  {3'b000, e.zero});
        chk("neg",   {3'b000, bus.neg},   {3'b000, e.neg});
      end
    end
  end

  // Issue one command and return once it has been accepted.
  task automatic send(input logic [1:0] o, input logic [3:0] d, input exp_t e);
    bit ok;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.operand  = d;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait until every pending result has been consumed.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [3:0] hold_acc;
    logic [3:0] sat_pos;
    logic [3:0] sat_neg;
    int         vcount;
    total = 0;
    bad   = 0;
`ifdef ACC_SATURATE_EN
    sat_pos = 4'b0111;
    sat_neg = 4'b1000;
`else
    sat_pos = 4'b1010;
    sat_neg = 4'b0110;
`endif
    bus.in_valid  = 1'b0;
    bus.op        = OP_LOAD;
    bus.operand   = 4'b0000;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    // Reset state
    #2;
    chk("rst_acc",       bus.acc,                4'b0000);
    chk("rst_zero",      {3'b000, bus.zero},      4'b0001);
    chk("rst_neg",       {3'b000, bus.neg},       4'b0000);
    chk("rst_out_valid", {3'b000, bus.out_valid}, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {3'b000, bus.in_ready}, 4'b0001);

    // Mid-clock asynchronous reset clears a loaded accumulator immediately
    send(OP_LOAD, 4'b0101, mk(4'b0101, 1'b0, 1'b0));
    drain();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_acc",       bus.acc,                4'b0000);
    chk("async_rst_zero",      {3'b000, bus.zero},      4'b0001);
    chk("async_rst_out_valid", {3'b000, bus.out_valid}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_in_ready", {3'b000, bus.in_ready}, 4'b0001);

    // Borrow and carry through zero
    send(OP_LOAD, 4'b0001, mk(4'b0001, 1'b0, 1'b0));
    send(OP_SUB,  4'b0010, mk(4'b1111, 1'b0, 1'b0));
    send(OP_ADD,  4'b0010, mk(4'b0001, 1'b1, 1'b0));
    // Positive overflow
    send(OP_LOAD, 4'b0110, mk(4'b0110, 1'b0, 1'b0));
    send(OP_ADD,  4'b0100, mk(sat_pos, 1'b0, 1'b1));
    // Negative results, with and without overflow
    send(OP_LOAD, 4'b1010, mk(4'b1010, 1'b0, 1'b0));
    send(OP_SUB,  4'b1100, mk(4'b1110, 1'b0, 1'b0));
    send(OP_LOAD, 4'b1010, mk(4'b1010, 1'b0, 1'b0));
    send(OP_SUB,  4'b0100, mk(sat_neg, 1'b1, 1'b1));
    drain();

    // Backpressure: result held for 5 cycles, CLEAR pulses ignored
    bus.out_ready = 1'b0;
    send(OP_LOAD, 4'b0011, mk(4'b0011, 1'b0, 1'b0));
    vcount = 0;
    while (!bus.out_valid && vcount < 10) begin
      @(negedge clk);
      vcount++;
    end
    chk("bp_out_valid", {3'b000, bus.out_valid}, 4'b0001);
    hold_acc = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i % 2 == 0);
      bus.op       = OP_CLEAR;
      @(negedge clk);
      chk("bp_acc_hold",  bus.acc,                hold_acc);
      chk("bp_zero_hold", {3'b000, bus.zero},      4'b0000);
      chk("bp_in_ready",  {3'b000, bus.in_ready},  4'b0000);
      chk("bp_valid",     {3'b000, bus.out_valid}, 4'b0001);
    end
    // Release with the next command already waiting
    sb.push_back(mk(4'b0100, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.operand   = 4'b0001;
    @(negedge clk);
    chk("rel_in_ready_0", {3'b000, bus.in_ready}, 4'b0000);
    @(negedge clk);
    chk("rel_in_ready_1", {3'b000, bus.in_ready}, 4'b0001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    // Reset during EXEC of ADD 0011 discards the result
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.operand  = 4'b0011;
    @(posedge clk); #3;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("exec_rst_acc",   bus.acc,                4'b0000);
    chk("exec_rst_valid", {3'b000, bus.out_valid}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("exec_rst_no_pulse", vcount[3:0], 4'b0000);
    send(OP_CLEAR, 4'b0110, mk(4'b0000, 1'b0, 1'b0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog keeps the run bounded even if a handshake stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: got no completion expected finish before 20000");
    $fatal(1);
  end

endmodule
`default_nettype wire
